gen_board_ai: RTL and testbench
===============================

GEN_BOARD_AI -- requirements
Module: gen_board_ai

Interface
REQ-001 N, 3, board dimension; legal 3..8.
REQ-002 K, 3, win length in a line; legal 3..N.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 board_state  in  2*N*N  cell (r,c) at bits [2*(r*N+c)+:2]; 0=opponent, 1=AI, 2=empty, 3=blocked (never playable, never counts toward a line).
REQ-006 start  in  1  request one evaluation of board_state.
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 done  out  1  one-cycle pulse when results are valid.
REQ-009 next_row, next_col  out  $clog2(N) each  selected AI move.
REQ-010 move_valid  out  1  next_row/next_col hold a legal move.
REQ-011 game_over  out  1  board already won or drawn.
REQ-012 winner  out  2  0=opponent, 1=AI, 2=draw, 3=none.

Function
REQ-013 States: IDLE, CHK, AIW, OPW, FALL, DONE; one cell index idx (0..N*N-1, raster order) is shared by CHK/AIW/OPW.
REQ-014 IDLE: start=1 at a clock edge captures board_state into an internal snapshot, sets idx=0 and busy=1, and enters CHK; start outside IDLE is ignored.
REQ-015 CHK: per cycle, test whether a K-long line of one player starts at idx (right, down, and diagonals per REQ-027); a hit sets game_over=1, winner=that player, move_valid=0 and enters DONE.
REQ-016 CHK also records the first empty cell and whether any empty cell exists; at idx=N*N-1 with no hit, no empty cell gives game_over=1, winner=2 and DONE; otherwise idx=0 and AIW.
REQ-017 AIW: per cycle, if cell idx is empty and placing AI there completes a K-line through it, latch the move with move_valid=1 and enter DONE; at idx=N*N-1 with no hit, wrap idx=0 and enter OPW.
REQ-018 OPW: identical test for the opponent (block); a hit latches the move with move_valid=1 and enters DONE; otherwise OPW enters FALL after idx=N*N-1.
REQ-019 FALL: one cycle; pick the centre (N/2,N/2) if empty, else the recorded first empty cell; move_valid=1; enter DONE.
REQ-020 Priority: a win found in CHK beats an AI win, an AI win beats a block, and a block beats the fallback; the first hit in raster order wins within a phase.
REQ-021 DONE: done=1 for exactly one cycle, busy=0 on the next edge, return to IDLE; outputs hold until the next accepted start.
REQ-022 Worst-case latency: done is high in cycle 3*N*N+2 after the start edge (29 for N=3); early exits are shorter.
REQ-023 An accepted start clears move_valid, game_over and done, and sets winner=3.
REQ-024 Changes on board_state after capture have no effect on the current evaluation.

Reset
REQ-025 rst=1 forces IDLE immediately: busy=0, done=0, move_valid=0, game_over=0, winner=3, next_row=0, next_col=0, idx=0.
REQ-026 Reset mid-evaluation discards it; the first start after rst deasserts is accepted normally.

Configuration
REQ-027 Macro GEN_BOARD_AI_DIAG_EN: when defined, CHK/AIW/OPW also test both diagonal directions; when undefined, only horizontal and vertical lines count, and latency is unchanged.

Structure
REQ-028 Package gen_board_ai_pkg holds the cell codes, the winner codes and the state enumeration.
REQ-029 Sub-module gen_board_ai_line_chk (combinational): takes the snapshot, the cell index, the player and the mode (line-start or through-cell) and returns a hit flag; it is instantiated once per phase use.

Verification
REQ-030 Empty board, start -> done at cycle 29, move (1,1), move_valid=1, game_over=0, winner=3.
REQ-031 AI at (0,0),(0,1); opponent at (1,0),(1,1) -> move (0,2) (win beats block).
REQ-032 Opponent at (2,0),(2,1); AI at (1,1) -> move (2,2).
REQ-033 AI fills row 0 -> game_over=1, winner=1, move_valid=0, done at cycle 2; full board with no line -> winner=2.
REQ-034 Opponent at (0,0),(1,1); AI at (0,1) -> with GEN_BOARD_AI_DIAG_EN move (2,2); without it move (0,2).
REQ-035 rst pulsed while busy=1 in AIW -> all outputs at reset values; the next start completes correctly; start while busy -> no restart and no extra done.

Source files
------------

// File: rtl/gen_board_ai_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gen_board_ai_pkg
// Description : Cell/winner codes, FSM states and line-direction helpers for
//               the board-game move selector (GEN_BOARD_AI_DIAG_EN adds
//               diagonal lines).
// Revision    : 1.0 - initial release
// ============================================================================
package gen_board_ai_pkg;

    localparam logic [1:0] c_cell_opp   = 2'd0;
    localparam logic [1:0] c_cell_ai    = 2'd1;
    localparam logic [1:0] c_cell_empty = 2'd2;
    localparam logic [1:0] c_cell_block = 2'd3;

    localparam logic [1:0] c_win_opp  = 2'd0;
    localparam logic [1:0] c_win_ai   = 2'd1;
    localparam logic [1:0] c_win_draw = 2'd2;
    localparam logic [1:0] c_win_none = 2'd3;

    // line starting at the cell vs. any line passing through the cell
    localparam logic c_mode_start = 1'b0;
    localparam logic c_mode_thru  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_AIW  = 3'd2,
        S_OPW  = 3'd3,
        S_FALL = 3'd4,
        S_DONE = 3'd5
    } state_t;

`ifdef GEN_BOARD_AI_DIAG_EN
    localparam int c_num_dirs = 4;
`else
    localparam int c_num_dirs = 2;
`endif

    // directions: 0 right, 1 down, 2 down-right, 3 down-left
    function automatic int dir_dr(input int d);
        case (d)
            0:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int dir_dc(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            2:       return 1;
            default: return -1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gen_board_ai_line_chk.sv
`default_nettype none
// ============================================================================
// Module      : gen_board_ai_line_chk
// Description : Combinational K-in-a-line detector for one player at one cell,
//               either as the line start or as a cell the line passes through.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_board_ai_line_chk
    import gen_board_ai_pkg::*;
#(
    parameter int N    = 3,
    parameter int K    = 3,
    parameter int IDXW = $clog2(N*N)
)
(
    input  logic [2*N*N-1:0] snapshot,
    input  logic [IDXW-1:0]  idx,
    input  logic [1:0]       player,
    input  logic             mode,
    output logic             hit
);

    int   w_r0, w_c0, w_dr, w_dc, w_sr, w_sc, w_rr, w_cc;
    logic w_run_ok;

    // In through-cell mode the cell at idx is treated as already holding player.
    always_comb begin
        hit      = 1'b0;
        w_r0     = int'(idx) / N;
        w_c0     = int'(idx) % N;
        w_dr     = 0;
        w_dc     = 0;
        w_sr     = 0;
        w_sc     = 0;
        w_rr     = 0;
        w_cc     = 0;
        w_run_ok = 1'b0;
        for (int d = 0; d < c_num_dirs; d++) begin
            w_dr = dir_dr(d);
            w_dc = dir_dc(d);
            for (int o = 0; o < K; o++) begin
                if (o == 0 || mode == c_mode_thru) begin
                    w_sr     = w_r0 - o * w_dr;
                    w_sc     = w_c0 - o * w_dc;
                    w_run_ok = 1'b1;
                    for (int k = 0; k < K; k++) begin
                        w_rr = w_sr + k * w_dr;
                        w_cc = w_sc + k * w_dc;
                        if (w_rr < 0 || w_rr >= N || w_cc < 0 || w_cc >= N) begin
                            w_run_ok = 1'b0;
                        end else if (!(mode == c_mode_thru && w_rr == w_r0 && w_cc == w_c0) &&
                                     snapshot[2*(w_rr*N + w_cc) +: 2] != player) begin
                            w_run_ok = 1'b0;
                        end
                    end
                    if (w_run_ok) begin
                        hit = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gen_board_ai.sv
`default_nettype none
// ============================================================================
// Module      : gen_board_ai
// Description : Sequential board scanner: detects finished games, then picks a
//               winning move, a blocking move or a fallback cell.
//               Define GEN_BOARD_AI_DIAG_EN to also score diagonal lines.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_board_ai
    import gen_board_ai_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*N*N-1:0]     board_state,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] next_row,
    output logic [$clog2(N)-1:0] next_col,
    output logic                 move_valid,
    output logic                 game_over,
    output logic [1:0]           winner
);

    localparam int c_idxw = $clog2(N*N);
    localparam int c_rcw  = $clog2(N);
    localparam logic [c_idxw-1:0] c_last   = c_idxw'(N*N - 1);
    localparam logic [c_idxw-1:0] c_one    = c_idxw'(1);
    localparam logic [c_idxw-1:0] c_centre = c_idxw'((N/2)*N + N/2);

    state_t              r_state;
    logic [2*N*N-1:0]    r_snap;
    logic [c_idxw-1:0]   r_idx;
    logic [c_idxw-1:0]   r_first_empty;
    logic                r_have_empty;
    logic                r_busy;
    logic                r_done;
    logic                r_move_valid;
    logic                r_game_over;
    logic [1:0]          r_winner;
    logic [c_rcw-1:0]    r_next_row;
    logic [c_rcw-1:0]    r_next_col;

    logic w_chk_ai, w_chk_op, w_win_ai, w_blk_op;
    logic w_cell_empty, w_centre_empty;

    function automatic logic [c_rcw-1:0] row_of(input logic [c_idxw-1:0] i);
        return c_rcw'(i / c_idxw'(N));
    endfunction

    function automatic logic [c_rcw-1:0] col_of(input logic [c_idxw-1:0] i);
        return c_rcw'(i % c_idxw'(N));
    endfunction

    assign w_cell_empty   = (r_snap[{r_idx, 1'b0} +: 2] == c_cell_empty);
    assign w_centre_empty = (r_snap[2*int'(c_centre) +: 2] == c_cell_empty);

    gen_board_ai_line_chk #(.N(N), .K(K), .IDXW(c_idxw)) u_chk_ai (
        .snapshot(r_snap), .idx(r_idx), .player(c_cell_ai),  .mode(c_mode_start), .hit(w_chk_ai)
    );
    gen_board_ai_line_chk #(.N(N), .K(K), .IDXW(c_idxw)) u_chk_op (
        .snapshot(r_snap), .idx(r_idx), .player(c_cell_opp), .mode(c_mode_start), .hit(w_chk_op)
    );
    gen_board_ai_line_chk #(.N(N), .K(K), .IDXW(c_idxw)) u_win_ai (
        .snapshot(r_snap), .idx(r_idx), .player(c_cell_ai),  .mode(c_mode_thru),  .hit(w_win_ai)
    );
    gen_board_ai_line_chk #(.N(N), .K(K), .IDXW(c_idxw)) u_blk_op (
        .snapshot(r_snap), .idx(r_idx), .player(c_cell_opp), .mode(c_mode_thru),  .hit(w_blk_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_snap        <= '0;
            r_idx         <= '0;
            r_first_empty <= '0;
            r_have_empty  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_move_valid  <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= c_win_none;
            r_next_row    <= '0;
            r_next_col    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_snap        <= board_state;
                        r_idx         <= '0;
                        r_first_empty <= '0;
                        r_have_empty  <= 1'b0;
                        r_busy        <= 1'b1;
                        r_move_valid  <= 1'b0;
                        r_game_over   <= 1'b0;
                        r_winner      <= c_win_none;
                        r_state       <= S_CHK;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_CHK: begin
                    if (w_chk_ai || w_chk_op) begin
                        r_game_over  <= 1'b1;
                        r_winner     <= w_chk_ai ? c_win_ai : c_win_opp;
                        r_move_valid <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        if (w_cell_empty && !r_have_empty) begin
                            r_have_empty  <= 1'b1;
                            r_first_empty <= r_idx;
                        end
                        if (r_idx == c_last) begin
                            r_idx <= '0;
                            if (!(r_have_empty || w_cell_empty)) begin
                                r_game_over <= 1'b1;
                                r_winner    <= c_win_draw;
                                r_state     <= S_DONE;
                            end else begin
                                r_state <= S_AIW;
                            end
                        end else begin
                            r_idx <= r_idx + c_one;
                        end
                    end
                end
                S_AIW: begin
                    if (w_cell_empty && w_win_ai) begin
                        r_next_row   <= row_of(r_idx);
                        r_next_col   <= col_of(r_idx);
                        r_move_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (r_idx == c_last) begin
                        r_idx   <= '0;
                        r_state <= S_OPW;
                    end else begin
                        r_idx <= r_idx + c_one;
                    end
                end
                S_OPW: begin
                    if (w_cell_empty && w_blk_op) begin
                        r_next_row   <= row_of(r_idx);
                        r_next_col   <= col_of(r_idx);
                        r_move_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (r_idx == c_last) begin
                        r_idx   <= '0;
                        r_state <= S_FALL;
                    end else begin
                        r_idx <= r_idx + c_one;
                    end
                end
                S_FALL: begin
                    r_next_row   <= w_centre_empty ? row_of(c_centre) : row_of(r_first_empty);
                    r_next_col   <= w_centre_empty ? col_of(c_centre) : col_of(r_first_empty);
                    r_move_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign next_row   = r_next_row;
    assign next_col   = r_next_col;
    assign move_valid = r_move_valid;
    assign game_over  = r_game_over;
    assign winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_gen_board_ai.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_board_ai
// Description : Directed self-checking bench for gen_board_ai (N=K=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_board_ai;

    localparam logic [17:0] c_empty = 18'h2AAAA;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [17:0] board_state;
    logic        busy, done, move_valid, game_over;
    logic [1:0]  next_row, next_col, winner;

    int n_cmp  = 0;
    int n_fail = 0;

    gen_board_ai #(.N(3), .K(3)) dut (
        .clk(clk), .rst(rst), .board_state(board_state), .start(start),
        .busy(busy), .done(done), .next_row(next_row), .next_col(next_col),
        .move_valid(move_valid), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] put(input logic [17:0] b, input int r, input int c,
                                        input logic [1:0] v);
        logic [17:0] t;
        t = b;
        t[2*(r*3+c) +: 2] = v;
        return t;
    endfunction

    task automatic run_eval(input logic [17:0] bs, input logic [17:0] bs_after, output int cyc);
        board_state = bs;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        board_state = bs_after;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input int cyc, input int e_cyc,
                                input int e_row, input int e_col, input int e_mv,
                                input int e_go, input int e_win);
        check($sformatf("%s cycle", tag), cyc, e_cyc);
        check($sformatf("%s move_valid", tag), 32'(move_valid), e_mv);
        check($sformatf("%s game_over", tag), 32'(game_over), e_go);
        check($sformatf("%s winner", tag), 32'(winner), e_win);
        if (e_mv == 1) begin
            check($sformatf("%s row", tag), 32'(next_row), e_row);
            check($sformatf("%s col", tag), 32'(next_col), e_col);
        end
    endtask

    initial begin
        logic [17:0] b;
        int cyc;
        int pulses;
        int done_cyc;

        rst = 1'b1;
        start = 1'b0;
        board_state = c_empty;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst move_valid", 32'(move_valid), 0);
        check("rst game_over", 32'(game_over), 0);
        check("rst winner", 32'(winner), 3);
        check("rst row", 32'(next_row), 0);
        check("rst col", 32'(next_col), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // empty board -> centre, worst-case latency
        run_eval(c_empty, c_empty, cyc);
        check_result("empty", cyc, 29, 1, 1, 1, 0, 3);
        check("empty busy@done", 32'(busy), 1);
        @(posedge clk); #1;
        check("empty busy after", 32'(busy), 0);
        check("empty done pulse", 32'(done), 0);
        check("empty row held", 32'(next_row), 1);

        // AI win beats block
        b = c_empty;
        b = put(b, 0, 0, 2'd1); b = put(b, 0, 1, 2'd1);
        b = put(b, 1, 0, 2'd0); b = put(b, 1, 1, 2'd0);
        run_eval(b, b, cyc);
        check_result("aiwin", cyc, 13, 0, 2, 1, 0, 3);

        // block opponent row
        b = c_empty;
        b = put(b, 2, 0, 2'd0); b = put(b, 2, 1, 2'd0); b = put(b, 1, 1, 2'd1);
        run_eval(b, b, cyc);
        check_result("block", cyc, 28, 2, 2, 1, 0, 3);

        // AI already won row 0
        b = c_empty;
        b = put(b, 0, 0, 2'd1); b = put(b, 0, 1, 2'd1); b = put(b, 0, 2, 2'd1);
        run_eval(b, b, cyc);
        check_result("aiwon", cyc, 2, 0, 0, 0, 1, 1);

        // opponent already won column 1
        b = c_empty;
        b = put(b, 0, 1, 2'd0); b = put(b, 1, 1, 2'd0); b = put(b, 2, 1, 2'd0);
        run_eval(b, b, cyc);
        check_result("opwon", cyc, 3, 0, 0, 0, 1, 0);

        // full board, no line -> draw
        b = c_empty;
        b = put(b, 0, 0, 2'd1); b = put(b, 0, 1, 2'd0); b = put(b, 0, 2, 2'd1);
        b = put(b, 1, 0, 2'd1); b = put(b, 1, 1, 2'd0); b = put(b, 1, 2, 2'd0);
        b = put(b, 2, 0, 2'd0); b = put(b, 2, 1, 2'd1); b = put(b, 2, 2, 2'd1);
        run_eval(b, b, cyc);
        check_result("draw", cyc, 10, 0, 0, 0, 1, 2);

        // diagonal threat
        b = c_empty;
        b = put(b, 0, 0, 2'd0); b = put(b, 1, 1, 2'd0); b = put(b, 0, 1, 2'd1);
        run_eval(b, b, cyc);
`ifdef GEN_BOARD_AI_DIAG_EN
        check_result("diag", cyc, 28, 2, 2, 1, 0, 3);
`else
        check_result("diag", cyc, 29, 0, 2, 1, 0, 3);
`endif

        // blocked centre -> first empty cell
        b = put(c_empty, 1, 1, 2'd3);
        run_eval(b, b, cyc);
        check_result("blkcentre", cyc, 29, 0, 0, 1, 0, 3);

        // blocked cell breaks the AI row
        b = c_empty;
        b = put(b, 0, 0, 2'd1); b = put(b, 0, 1, 2'd1); b = put(b, 0, 2, 2'd3);
        run_eval(b, b, cyc);
        check_result("blkline", cyc, 29, 1, 1, 1, 0, 3);

        // input changes after capture are ignored
        b = c_empty;
        b = put(b, 0, 0, 2'd1); b = put(b, 0, 1, 2'd1); b = put(b, 0, 2, 2'd1);
        run_eval(c_empty, b, cyc);
        check_result("capture", cyc, 29, 1, 1, 1, 0, 3);

        // reset while in AIW
        board_state = c_empty;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 0);
        check("midrst done", 32'(done), 0);
        check("midrst move_valid", 32'(move_valid), 0);
        check("midrst game_over", 32'(game_over), 0);
        check("midrst winner", 32'(winner), 3);
        check("midrst row", 32'(next_row), 0);
        check("midrst col", 32'(next_col), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst idle busy", 32'(busy), 0);
        b = c_empty;
        b = put(b, 0, 0, 2'd1); b = put(b, 0, 1, 2'd1);
        b = put(b, 1, 0, 2'd0); b = put(b, 1, 1, 2'd0);
        run_eval(b, b, cyc);
        check_result("afterrst", cyc, 13, 0, 2, 1, 0, 3);

        // start while busy is ignored
        b = c_empty;
        b = put(b, 0, 0, 2'd1); b = put(b, 0, 1, 2'd1); b = put(b, 0, 2, 2'd1);
        board_state = c_empty;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        pulses = 0;
        done_cyc = 0;
        while (cyc < 45) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                pulses++;
                done_cyc = cyc;
            end
            if (cyc == 5) begin
                start = 1'b1;
                board_state = b;
            end
            if (cyc == 6) begin
                start = 1'b0;
            end
        end
        check("busystart pulses", pulses, 1);
        check("busystart cycle", done_cyc, 29);
        check("busystart row", 32'(next_row), 1);
        check("busystart col", 32'(next_col), 1);
        check("busystart game_over", 32'(game_over), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
